// File: rtl/design124_channel_sched.sv
// Round-robin channel scheduler feeding a fixed-latency datapath.
// Grants up to BURST beats per channel and tags each issued beat so its result returns with the owner.
module design124_channel_sched #(
   parameter int CHANNEL = 20,
   parameter int LATENCY = 12,
   parameter int BURST   = 4,
   localparam int CW     = (CHANNEL > 1) ? $clog2(CHANNEL) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [CHANNEL-1:0] req,
   input  logic [CHANNEL-1:0] en_mask,
   input  logic               flush,
   input  logic               dp_ready,
   output logic [CHANNEL-1:0] gnt,
   output logic               dp_valid,
   output logic [CW-1:0]      dp_sel,
   output logic               rsp_valid,
   output logic [CW-1:0]      rsp_chan,
   output logic               busy
);

   localparam int BW = $clog2(BURST + 1);
   localparam int IW = $clog2(LATENCY + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                      state, state_n;
   logic [CHANNEL-1:0]          elig, gnt_n;
   logic                        dp_valid_n, busy_n;
   logic [CW-1:0]               dp_sel_n, ptr, ptr_n, win;
   logic                        win_ok;
   logic [BW-1:0]               beat_cnt, beat_n;
   logic [IW-1:0]               infl, infl_n;
   logic                        xfer, rsp_in;
   logic [LATENCY-1:0]          vld_pipe;
   logic [LATENCY-1:0][CW-1:0]  chan_pipe;

   assign elig   = req & en_mask;
   assign xfer   = dp_valid & dp_ready;
   assign rsp_in = vld_pipe[LATENCY-1];

   // first eligible channel at or above ptr, wrapping
   always_comb begin
      win    = '0;
      win_ok = 1'b0;
      for (int i = 0; i < CHANNEL; i++) begin
         if (!win_ok && elig[(int'(ptr) + i) % CHANNEL]) begin
            win_ok = 1'b1;
            win    = CW'((int'(ptr) + i) % CHANNEL);
         end
      end
   end

   always_comb begin
      state_n    = state;
      gnt_n      = gnt;
      dp_valid_n = dp_valid;
      dp_sel_n   = dp_sel;
      ptr_n      = ptr;
      beat_n     = beat_cnt;
      case (state)
         IDLE: begin
            if (flush) begin
               ptr_n = '0;
            end else if (win_ok) begin
               state_n    = ISSUE;
               gnt_n      = '0;
               gnt_n[win] = 1'b1;
               dp_valid_n = 1'b1;
               dp_sel_n   = win;
               beat_n     = '0;
            end
         end
         ISSUE: begin
            if (flush) begin
               state_n    = DRAIN;
               gnt_n      = '0;
               dp_valid_n = 1'b0;
               beat_n     = '0;
            end else if (xfer) begin
               // req/en_mask of the owner are only looked at on a beat boundary
               if (beat_cnt == BW'(BURST - 1) || !req[dp_sel] || !en_mask[dp_sel]) begin
                  state_n    = IDLE;
                  gnt_n      = '0;
                  dp_valid_n = 1'b0;
                  beat_n     = '0;
                  ptr_n      = (dp_sel == CW'(CHANNEL - 1)) ? '0 : dp_sel + 1'b1;
               end else begin
                  beat_n = beat_cnt + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (infl == '0) begin
               state_n = IDLE;
               ptr_n   = '0;
            end
         end
         default: state_n = IDLE;
      endcase

      infl_n = infl;
      if (xfer && !rsp_in)      infl_n = infl + 1'b1;
      else if (!xfer && rsp_in) infl_n = infl - 1'b1;

      busy_n = (state_n != IDLE) || (infl_n != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         gnt       <= '0;
         dp_valid  <= 1'b0;
         dp_sel    <= '0;
         ptr       <= '0;
         beat_cnt  <= '0;
         infl      <= '0;
         busy      <= 1'b0;
         vld_pipe  <= '0;
         chan_pipe <= '0;
         rsp_valid <= 1'b0;
         rsp_chan  <= '0;
      end else begin
         state        <= state_n;
         gnt          <= gnt_n;
         dp_valid     <= dp_valid_n;
         dp_sel       <= dp_sel_n;
         ptr          <= ptr_n;
         beat_cnt     <= beat_n;
         infl         <= infl_n;
         busy         <= busy_n;
         vld_pipe[0]  <= xfer;
         chan_pipe[0] <= dp_sel;
         for (int i = 1; i < LATENCY; i++) begin
            vld_pipe[i]  <= vld_pipe[i-1];
            chan_pipe[i] <= chan_pipe[i-1];
         end
         rsp_valid <= vld_pipe[LATENCY-1];
         rsp_chan  <= chan_pipe[LATENCY-1];
      end
   end

endmodule

// File: tb/tb_design124_channel_sched.sv
// Bench for design124_channel_sched: directed scenarios plus random traffic,
// compared each cycle against an owner/queue reference model.
module tb_design124_channel_sched;

   localparam int CHANNEL = 20;
   localparam int LATENCY = 12;
   localparam int BURST   = 4;
   localparam int CW      = 5;

   logic               clk = 1'b0;
   logic               rst;
   logic [CHANNEL-1:0] req, en_mask, gnt;
   logic               flush, dp_ready, dp_valid, rsp_valid, busy;
   logic [CW-1:0]      dp_sel, rsp_chan;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   design124_channel_sched #(.CHANNEL(CHANNEL), .LATENCY(LATENCY), .BURST(BURST)) dut (
      .clk(clk), .rst(rst), .req(req), .en_mask(en_mask), .flush(flush),
      .dp_ready(dp_ready), .gnt(gnt), .dp_valid(dp_valid), .dp_sel(dp_sel),
      .rsp_valid(rsp_valid), .rsp_chan(rsp_chan), .busy(busy)
   );

   // reference model: current owner (-1 none), drain flag, queue of pending results
   int m_owner, m_beats, m_ptr, m_sel, m_rsp_chan, ecyc;
   bit m_drain, m_dpv, m_rsp;
   int q_due[$];
   int q_chan[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_beats = 0; m_ptr = 0; m_sel = 0;
      m_drain = 0; m_dpv = 0; m_rsp = 0; m_rsp_chan = 0;
      q_due.delete(); q_chan.delete();
   endtask

   task automatic model_step();
      bit xfer;
      int qpre;
      ecyc++;
      xfer = m_dpv && dp_ready;
      qpre = q_due.size();
      if (xfer) begin
         q_due.push_back(ecyc + LATENCY);
         q_chan.push_back(m_sel);
      end
      if (m_owner < 0 && !m_drain) begin
         if (flush) m_ptr = 0;
         else begin
            for (int i = 0; i < CHANNEL; i++) begin
               int k;
               k = (m_ptr + i) % CHANNEL;
               if (m_owner < 0 && req[k] && en_mask[k]) begin
                  m_owner = k; m_beats = 0; m_dpv = 1; m_sel = k;
               end
            end
         end
      end else if (m_owner >= 0) begin
         if (flush) begin
            m_owner = -1; m_dpv = 0; m_drain = 1; m_beats = 0;
         end else if (xfer) begin
            m_beats++;
            if (m_beats == BURST || !req[m_owner] || !en_mask[m_owner]) begin
               m_ptr = (m_owner + 1) % CHANNEL;
               m_owner = -1; m_dpv = 0; m_beats = 0;
            end
         end
      end else if (m_drain && qpre == 0) begin
         m_drain = 0; m_ptr = 0;
      end
      m_rsp = 0;
      if (q_due.size() > 0 && q_due[0] == ecyc) begin
         m_rsp = 1; m_rsp_chan = q_chan[0];
         void'(q_due.pop_front());
         void'(q_chan.pop_front());
      end
   endtask

   task automatic compare();
      chk("gnt", 32'(gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("dp_valid", 32'(dp_valid), 32'(m_dpv));
      chk("dp_sel", 32'(dp_sel), 32'(m_sel));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
      if (m_rsp) chk("rsp_chan", 32'(rsp_chan), 32'(m_rsp_chan));
      chk("busy", 32'(busy), 32'(m_owner >= 0 || m_drain || q_due.size() > 0));
   endtask

   task automatic tick();
      if (rst) model_step();
      else     model_reset();
      @(posedge clk);
      #1;
      compare();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      ecyc = 0;
      rst = 1'b1; req = '0; en_mask = '1; flush = 1'b0; dp_ready = 1'b0;
      model_reset();
      #1 rst = 1'b0;
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_dp_valid", 32'(dp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      run(2);
      rst = 1'b1;

      // single requester, continuous ready: bursts of 4 separated by a bubble
      req = 20'h00001; dp_ready = 1'b1;
      run(40);
      req = '0; run(16);

      // flush in idle resets the pointer, then three requesters rotate
      flush = 1'b1; run(1); flush = 1'b0;
      req = 20'h80005;
      run(25);
      req = '0; run(16);

      // stall: beat held steady, one transfer once ready rises
      req = 20'h00002; dp_ready = 1'b0;
      run(6);
      dp_ready = 1'b1; req = '0;
      run(16);

      // flush after two transfers, then drain and restart from channel 0
      req = 20'h00001; dp_ready = 1'b1;
      run(3);
      flush = 1'b1; dp_ready = 1'b0;
      run(1);
      flush = 1'b0; req = '0;
      run(16);
      req = '1; run(3);
      req = '0; dp_ready = 1'b1; run(18);

      // all channels masked, then only channel 7 enabled
      req = '1; en_mask = '0;
      run(5);
      en_mask = 20'h00080;
      run(3);
      req = '0; en_mask = '1;
      run(16);

      // reset with beats in flight
      req = '1; dp_ready = 1'b1;
      run(8);
      rst = 1'b0;
      #1;
      chk("arst_gnt", 32'(gnt), 32'd0);
      chk("arst_dp_valid", 32'(dp_valid), 32'd0);
      chk("arst_dp_sel", 32'(dp_sel), 32'd0);
      chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("arst_rsp_chan", 32'(rsp_chan), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      req = '0;
      run(2);
      rst = 1'b1;
      run(20);

      // random traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 9) < 3) req = CHANNEL'($urandom() & $urandom());
         if ($urandom_range(0, 19) == 0) en_mask = CHANNEL'($urandom() | $urandom());
         flush    = ($urandom_range(0, 39) == 0);
         dp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      flush = 1'b0; req = '0;
      run(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/design124_channel_sched.md
DESIGN124_CHANNEL_SCHED -- requirements
Module: design124_channel_sched

Interface
REQ-001 Parameter CHANNEL, default 20: number of requesting channels sharing the datapath.
REQ-002 Parameter LATENCY, default 12: fixed datapath issue-to-result latency in cycles.
REQ-003 Parameter BURST, default 4: maximum consecutive beats per grant.
REQ-004 Local width CW = clog2(CHANNEL), 5 at defaults.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1: sole clock, rising edge.
REQ-007 Port rst, input, 1: asynchronous active-low reset.
REQ-008 Port req, input, CHANNEL: per-channel request, level.
REQ-009 Port en_mask, input, CHANNEL: per-channel enable; 0 makes the channel ineligible.
REQ-010 Port flush, input, 1: synchronous abort of arbitration; in-flight results still delivered.
REQ-011 Port dp_ready, input, 1: datapath accepts the current beat.
REQ-012 Port gnt, output, CHANNEL: one-hot grant, all-zero when idle.
REQ-013 Port dp_valid, output, 1: beat issued to datapath.
REQ-014 Port dp_sel, output, CW: channel index of the issued beat.
REQ-015 Port rsp_valid, output, 1: datapath result available.
REQ-016 Port rsp_chan, output, CW: channel index owning the result.
REQ-017 Port busy, output, 1: state is not IDLE or in-flight count is nonzero.

Function
REQ-018 All outputs SHALL be registered; eligible = req & en_mask.
REQ-019 FSM states SHALL be IDLE, ISSUE, DRAIN.
REQ-020 IDLE: with eligible nonzero and flush low at edge t, go to ISSUE; gnt, dp_valid, dp_sel valid from edge t+1.
REQ-021 Round-robin: winner is the first eligible index searching upward from ptr, wrapping CHANNEL-1 to 0.
REQ-022 Beat transfer SHALL occur on any edge with dp_valid=1 and dp_ready=1; beat_cnt increments.
REQ-023 Once asserted, dp_valid and dp_sel SHALL hold until transfer or flush.
REQ-024 On transfer, the grant SHALL release at the next edge if beat_cnt reaches BURST, or req[k] or en_mask[k] is 0 in the transfer cycle.
REQ-025 On release of channel k: ptr = (k+1) mod CHANNEL, beat_cnt = 0, state returns to IDLE; this gives a one-cycle bubble before the next grant.
REQ-026 Changes to req or en_mask for the granted channel SHALL take effect only at beat boundaries.
REQ-027 Flush in ISSUE: gnt and dp_valid drop at the next edge and state goes to DRAIN; a transfer on the flush cycle still counts.
REQ-028 DRAIN: no grants; go to IDLE when in-flight count is 0; ptr is set to 0.
REQ-029 Flush in IDLE: ptr is set to 0 and no grant is issued that cycle.
REQ-030 Tracking: a LATENCY-stage shift register of {valid, chan}; a transfer at edge t gives rsp_valid=1 and rsp_chan=k for the single cycle after edge t+LATENCY.
REQ-031 In-flight counter SHALL span 0..LATENCY, with +1 per transfer and -1 per response; simultaneous events leave it unchanged.
REQ-032 Back-to-back transfers SHALL produce back-to-back responses in issue order.

Reset
REQ-033 On rst=0, asynchronously: state IDLE, gnt 0, dp_valid 0, dp_sel 0, rsp_valid 0, rsp_chan 0, busy 0, ptr 0, beat_cnt 0, shift register cleared.
REQ-034 Reset mid-operation SHALL discard all in-flight results; no rsp_valid follows reset release.

Verification
REQ-035 req=0x00001, dp_ready=1 held, req held -> gnt=0x00001 for 4 beats, one bubble, then 4 more beats; rsp_valid 12 cycles after each transfer with rsp_chan=0.
REQ-036 req=0x80005, dp_ready=1 -> grant order ch0, ch2, ch19, ch0, 4 beats each.
REQ-037 req=0x00002 with dp_ready=0 for 5 cycles -> dp_valid=1 and dp_sel=1 held stable, no response, then 1 transfer when dp_ready rises.
REQ-038 Flush asserted mid-burst after 2 transfers -> dp_valid=0 next cycle, state DRAIN, busy=1 until 2 responses arrive, then IDLE and ptr=0.
REQ-039 en_mask=0x00000 with req=0xFFFFF -> no grant and busy=0; setting en_mask bit 7 -> grant channel 7.
REQ-040 rst=0 pulsed with 6 beats in flight -> all outputs 0 immediately and no rsp_valid after release.
